assemble_block: RTL and testbench

- Upstream neighbour of the byte-streaming block stage: packs an incoming byte stream into 16-byte blocks (packed [15:0][7:0]) and presents each block to the downstream block consumer with a valid/ready handshake.
- Pads short final blocks (zero or PKCS#7).
- Optionally flushes stalled partial blocks after an idle timeout.
- Byte index 0 is the first byte received, so downstream streaming emits bytes in arrival order.

---
 rtl/assemble_block.sv | 193 +++++++++++++++++++
 tb/tb_assemble_block.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/assemble_block.sv
// Packs a byte stream into 16-byte blocks (element 0 = first byte) and hands
// each block downstream over valid/ready, with optional padding and idle flush.
module assemble_block #(
    parameter int PAD_MODE       = 1,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [7:0]       byte_in,
    input  logic             byte_valid_in,
    input  logic             byte_last_in,
    output logic             byte_ready_out,
    output logic [15:0][7:0] block_out,
    output logic             block_valid_out,
    input  logic             block_ready_in,
    output logic             block_last_out,
    output logic [4:0]       byte_count_out
);

    localparam int IW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [IW-1:0] IDLE_LAST = IW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic TO_EN = (TIMEOUT_CYCLES > 0);

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_HOLD = 2'd1,
        ST_XPAD = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [15:0][7:0]   block_q, block_d;
    logic [4:0]         count_q, count_d;
    logic [IW-1:0]      idle_q, idle_d;
    logic               valid_q, valid_d;
    logic               last_q, last_d;
    logic [4:0]         bcount_q, bcount_d;
    logic               pad_pend_q, pad_pend_d;
    logic               ready_q, ready_d;

    logic               byte_fire_s;
    logic               blk_fire_s;
    logic [4:0]         n_s;
    logic [7:0]         pad_s;

    // Next-state logic for the fill/hold/extra-pad sequencer
    always_comb begin
        state_d     = state_q;
        block_d     = block_q;
        count_d     = count_q;
        idle_d      = idle_q;
        valid_d     = valid_q;
        last_d      = last_q;
        bcount_d    = bcount_q;
        pad_pend_d  = pad_pend_q;
        byte_fire_s = byte_valid_in && ready_q;
        blk_fire_s  = valid_q && block_ready_in;
        n_s         = count_q + 5'd1;
        pad_s       = (PAD_MODE == 1) ? {3'b000, 5'd16 - n_s} : 8'h00;

        case (state_q)
            ST_FILL: begin
                if (byte_fire_s) begin
                    block_d[count_q[3:0]] = byte_in;
                    idle_d = '0;
                    if (byte_last_in) begin
                        for (int k = 0; k < 16; k++) begin
                            if (5'(k) >= n_s) begin
                                block_d[k] = pad_s;
                            end else begin
                                block_d[k] = block_d[k];
                            end
                        end
                        state_d  = ST_HOLD;
                        valid_d  = 1'b1;
                        bcount_d = n_s;
                        count_d  = n_s;
                        // A full final block under PKCS#7 needs a trailing all-pad block
                        if ((PAD_MODE == 1) && (n_s == 5'd16)) begin
                            last_d     = 1'b0;
                            pad_pend_d = 1'b1;
                        end else begin
                            last_d     = 1'b1;
                            pad_pend_d = 1'b0;
                        end
                    end else if (n_s == 5'd16) begin
                        state_d  = ST_HOLD;
                        valid_d  = 1'b1;
                        last_d   = 1'b0;
                        bcount_d = 5'd16;
                        count_d  = n_s;
                    end else begin
                        count_d = n_s;
                    end
                end else if (TO_EN && (count_q != 5'd0)) begin
                    // Flush fires on the idle cycle that would bring the counter to TIMEOUT_CYCLES
                    if (idle_q == IDLE_LAST) begin
                        for (int k = 0; k < 16; k++) begin
                            if (5'(k) >= count_q) begin
                                block_d[k] = 8'h00;
                            end else begin
                                block_d[k] = block_d[k];
                            end
                        end
                        state_d  = ST_HOLD;
                        valid_d  = 1'b1;
                        last_d   = 1'b0;
                        bcount_d = count_q;
                        idle_d   = '0;
                    end else begin
                        idle_d = idle_q + IW'(1);
                    end
                end else begin
                    idle_d = '0;
                end
            end
            ST_HOLD: begin
                if (blk_fire_s && pad_pend_q) begin
                    state_d    = ST_XPAD;
                    block_d    = {16{8'h10}};
                    valid_d    = 1'b1;
                    last_d     = 1'b1;
                    bcount_d   = 5'd0;
                    pad_pend_d = 1'b0;
                end else if (blk_fire_s) begin
                    state_d  = ST_FILL;
                    block_d  = '0;
                    count_d  = 5'd0;
                    valid_d  = 1'b0;
                    last_d   = 1'b0;
                    bcount_d = 5'd0;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            ST_XPAD: begin
                if (blk_fire_s) begin
                    state_d  = ST_FILL;
                    block_d  = '0;
                    count_d  = 5'd0;
                    valid_d  = 1'b0;
                    last_d   = 1'b0;
                    bcount_d = 5'd0;
                end else begin
                    state_d = ST_XPAD;
                end
            end
            default: begin
                state_d    = ST_FILL;
                block_d    = '0;
                count_d    = 5'd0;
                idle_d     = '0;
                valid_d    = 1'b0;
                last_d     = 1'b0;
                bcount_d   = 5'd0;
                pad_pend_d = 1'b0;
            end
        endcase

        ready_d = (state_d == ST_FILL);
    end

    // State and registered outputs
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= ST_FILL;
            block_q    <= '0;
            count_q    <= 5'd0;
            idle_q     <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            bcount_q   <= 5'd0;
            pad_pend_q <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            block_q    <= block_d;
            count_q    <= count_d;
            idle_q     <= idle_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
            bcount_q   <= bcount_d;
            pad_pend_q <= pad_pend_d;
            ready_q    <= ready_d;
        end
    end

    assign byte_ready_out  = ready_q;
    assign block_out       = block_q;
    assign block_valid_out = valid_q;
    assign block_last_out  = last_q;
    assign byte_count_out  = bcount_q;

endmodule

// File: tb/tb_assemble_block.sv
// Directed bench: a PKCS#7/timeout instance and a zero-pad instance share one stimulus stream.
module tb_assemble_block;

    logic             clk = 1'b0;
    logic             rst;
    logic [7:0]       byte_d;
    logic             bvalid;
    logic             blast;
    logic             bready;

    logic             p_ready, p_valid, p_last;
    logic [15:0][7:0] p_block;
    logic [4:0]       p_cnt;
    logic             z_ready, z_valid, z_last;
    logic [15:0][7:0] z_block;
    logic [4:0]       z_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    logic [15:0][7:0] exp_p, exp_z;

    always #5 clk = ~clk;

    assemble_block #(.PAD_MODE(1), .TIMEOUT_CYCLES(8)) u_p (
        .clk_in(clk), .rst_in(rst), .byte_in(byte_d), .byte_valid_in(bvalid),
        .byte_last_in(blast), .byte_ready_out(p_ready), .block_out(p_block),
        .block_valid_out(p_valid), .block_ready_in(bready),
        .block_last_out(p_last), .byte_count_out(p_cnt)
    );

    assemble_block #(.PAD_MODE(0), .TIMEOUT_CYCLES(0)) u_z (
        .clk_in(clk), .rst_in(rst), .byte_in(byte_d), .byte_valid_in(bvalid),
        .byte_last_in(blast), .byte_ready_out(z_ready), .block_out(z_block),
        .block_valid_out(z_valid), .block_ready_in(bready),
        .block_last_out(z_last), .byte_count_out(z_cnt)
    );

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] mk_blk(input logic [7:0] base, input int n, input logic [7:0] pad);
        logic [15:0][7:0] b;
        for (int k = 0; k < 16; k++) begin
            b[k] = (k < n) ? base + 8'(k) : pad;
        end
        return b;
    endfunction

    task automatic send_bytes(input logic [7:0] base, input int n, input logic with_last);
        for (int i = 0; i < n; i++) begin
            byte_d = base + 8'(i);
            blast  = with_last && (i == n - 1);
            bvalid = 1'b1;
            tick();
        end
        bvalid = 1'b0;
        blast  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; byte_d = 8'h00; bvalid = 1'b0; blast = 1'b0; bready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check_eq("rst_valid", {127'd0, p_valid}, 128'd0);
        check_eq("rst_block", p_block, 128'd0);
        check_eq("rst_ready", {127'd0, p_ready}, 128'd1);
        check_eq("rst_cnt", {123'd0, z_cnt}, 128'd0);

        // Full block without last
        send_bytes(8'h00, 16, 1'b0);
        check_eq("full_valid", {126'd0, p_valid, z_valid}, 128'd3);
        check_eq("full_block", p_block, mk_blk(8'h00, 16, 8'h00));
        check_eq("full_block_z", z_block, mk_blk(8'h00, 16, 8'h00));
        check_eq("full_cnt", {123'd0, p_cnt}, 128'd16);
        check_eq("full_last", {126'd0, p_last, z_last}, 128'd0);
        check_eq("full_ready", {126'd0, p_ready, z_ready}, 128'd0);
        tick();
        check_eq("full_drop", {126'd0, p_valid, z_valid}, 128'd0);
        check_eq("full_rdy_again", {126'd0, p_ready, z_ready}, 128'd3);
        check_eq("full_clear", p_block, 128'd0);

        // 13 bytes with last: PKCS pad 0x03 vs zero pad
        send_bytes(8'hA0, 13, 1'b1);
        check_eq("p13_block", p_block, mk_blk(8'hA0, 13, 8'h03));
        check_eq("p13_cnt", {123'd0, p_cnt}, 128'd13);
        check_eq("p13_last", {127'd0, p_last}, 128'd1);
        check_eq("z13_block", z_block, mk_blk(8'hA0, 13, 8'h00));
        check_eq("z13_last", {127'd0, z_last}, 128'd1);
        tick();
        check_eq("p13_drop", {126'd0, p_valid, z_valid}, 128'd0);

        // 16 bytes with last: extra pad block only for PKCS
        send_bytes(8'h40, 16, 1'b1);
        check_eq("p16_block", p_block, mk_blk(8'h40, 16, 8'h00));
        check_eq("p16_cnt", {123'd0, p_cnt}, 128'd16);
        check_eq("p16_last", {127'd0, p_last}, 128'd0);
        check_eq("z16_last", {127'd0, z_last}, 128'd1);
        check_eq("z16_cnt", {123'd0, z_cnt}, 128'd16);
        tick();
        check_eq("xpad_valid", {127'd0, p_valid}, 128'd1);
        check_eq("xpad_block", p_block, mk_blk(8'h00, 0, 8'h10));
        check_eq("xpad_cnt", {123'd0, p_cnt}, 128'd0);
        check_eq("xpad_last", {127'd0, p_last}, 128'd1);
        check_eq("xpad_ready", {127'd0, p_ready}, 128'd0);
        check_eq("z16_drop", {126'd0, z_valid, z_ready}, 128'd1);
        tick();
        check_eq("xpad_drop", {126'd0, p_valid, p_ready}, 128'd1);

        // 5 bytes with last under backpressure
        bready = 1'b0;
        send_bytes(8'h50, 5, 1'b1);
        exp_z = mk_blk(8'h50, 5, 8'h00);
        exp_p = mk_blk(8'h50, 5, 8'h0B);
        for (int c = 0; c < 10; c++) begin
            check_eq("stall_valid", {126'd0, p_valid, z_valid}, 128'd3);
            check_eq("stall_ready", {126'd0, p_ready, z_ready}, 128'd0);
            check_eq("stall_zblk", z_block, exp_z);
            check_eq("stall_pblk", p_block, exp_p);
            check_eq("stall_cnt", {118'd0, p_cnt, z_cnt}, {118'd0, 5'd5, 5'd5});
            tick();
        end
        bready = 1'b1;
        tick();
        check_eq("stall_release", {124'd0, p_valid, z_valid, p_ready, z_ready}, 128'd3);

        // Idle timeout flush after 8 idle cycles
        send_bytes(8'h60, 3, 1'b0);
        for (int c = 0; c < 7; c++) begin
            tick();
            check_eq("to_wait", {127'd0, p_valid}, 128'd0);
        end
        tick();
        check_eq("to_valid", {127'd0, p_valid}, 128'd1);
        check_eq("to_block", p_block, mk_blk(8'h60, 3, 8'h00));
        check_eq("to_cnt", {123'd0, p_cnt}, 128'd3);
        check_eq("to_last", {127'd0, p_last}, 128'd0);
        check_eq("to_nz", {127'd0, z_valid}, 128'd0);
        tick();
        check_eq("to_drop", {127'd0, p_valid}, 128'd0);
        do_reset();

        // Byte arriving on the expiry cycle suppresses the flush
        send_bytes(8'h70, 3, 1'b0);
        for (int c = 0; c < 7; c++) begin
            tick();
        end
        send_bytes(8'h73, 1, 1'b0);
        check_eq("exp_noflush", {127'd0, p_valid}, 128'd0);
        check_eq("exp_ready", {127'd0, p_ready}, 128'd1);
        send_bytes(8'h74, 12, 1'b0);
        check_eq("exp_block", p_block, mk_blk(8'h70, 16, 8'h00));
        check_eq("exp_cnt", {123'd0, p_cnt}, 128'd16);
        check_eq("exp_zblock", z_block, mk_blk(8'h70, 16, 8'h00));
        tick();

        // Reset while a block is held
        bready = 1'b0;
        send_bytes(8'h80, 16, 1'b0);
        check_eq("hold_valid", {126'd0, p_valid, z_valid}, 128'd3);
        do_reset();
        check_eq("rsthold_valid", {126'd0, p_valid, z_valid}, 128'd0);
        check_eq("rsthold_block", p_block, 128'd0);
        check_eq("rsthold_ready", {126'd0, p_ready, z_ready}, 128'd3);
        bready = 1'b1;
        send_bytes(8'h90, 16, 1'b0);
        check_eq("clean_block", p_block, mk_blk(8'h90, 16, 8'h00));
        check_eq("clean_cnt", {118'd0, p_cnt, z_cnt}, {118'd0, 5'd16, 5'd16});
        check_eq("clean_last", {126'd0, p_last, z_last}, 128'd0);
        tick();
        check_eq("clean_drop", {126'd0, p_valid, z_valid}, 128'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
